pin_activity_monitor: RTL and testbench
=======================================

// Module: pin_activity_monitor
// PURPOSE
//  Parametrised, restartable pin/short checker for the board self-test path. Samples NUM_CH
//  input pins in the clk_i domain over a programmable window. Flags per pin: has toggled;
//  not shorted to enabled neighbours (pair k/k+1 seen at opposite levels in both polarities).
//  Reports per-channel pass bits, a global pass and a done pulse for the test/OSD logic.
// PARAMETERS
//  NUM_CH         8  number of monitored pins (2..32)
//  WIN_W         16  width of window-length counter / win_len_i
//  SETTLE_CYCLES  4  cycles ignored after start before sampling (>=2 when sync compiled in)
// PORTS
//  clk_i        in   1        sampling/system clock
//  nrst_i       in   1        async active-low reset
//  start_i      in   1        start request; accepted only in IDLE or DONE
//  abort_i      in   1        cancel a running check
//  win_len_i    in   WIN_W    measure window in cycles, captured at start accept
//  tgl_mask_i   in   NUM_CH   1 = require toggle on channel k
//  adj_mask_i   in   NUM_CH   1 = check short between k and k+1 (MSB ignored)
//  pins_i       in   NUM_CH   monitored pins
//  busy_o       out  1        high in SETTLE, MEASURE, EVAL
//  done_o       out  1        one-cycle pulse when results update
//  ch_ok_o      out  NUM_CH   per-channel result, held until next done_o
//  pass_o       out  1        &ch_ok_o, updated with ch_ok_o
// BEHAVIOUR
//  Reset: state IDLE; busy_o=0, done_o=0, ch_ok_o=0, pass_o=0; all seen flags and counters 0.
//  FSM: IDLE -start_i-> SETTLE -(SETTLE_CYCLES cycles)-> MEASURE -(window)-> EVAL -(1)-> DONE.
//       DONE -start_i-> SETTLE, else stays DONE. abort_i in SETTLE/MEASURE/EVAL -> IDLE.
//  Start accept cycle t: win_len_i, tgl_mask_i and adj_mask_i captured. Seen flags cleared.
//  busy_o=1 from t+1.
//  start_i while busy is ignored. abort_i has priority over state progress.
//  Abort leaves ch_ok_o/pass_o unchanged and produces no done_o.
//  MEASURE lasts exactly win_len cycles. win_len_i==0 means 2^WIN_W cycles (counter wraps).
//  Per-channel sticky flags, set while MEASURE:
//   seen0[k]=pin k low.
//   seen1[k]=pin k high.
//   pA[k] = pin k low & pin k+1 high.
//   pB[k] = pin k high & pin k+1 low.
//  EVAL (1 cycle):
//   tgl_ok[k] = ~tgl_mask[k] | (seen0[k] & seen1[k]).
//   adj_ok[k] = ~adj_mask[k] | (pA[k] & pB[k]), for k<NUM_CH-1; adj_ok[NUM_CH-1]=1.
//   ch_ok[k] = tgl_ok[k] & adj_ok[k] & adj_ok[k-1]; adj_ok[-1]=1.
//   Registered into ch_ok_o/pass_o on the DONE entry edge, same cycle done_o=1.
//  Latency start accept -> done_o: SETTLE_CYCLES + win_len + 2 cycles.
//  Masks all 0 -> ch_ok_o all 1, pass_o=1.
//  Async reset mid-run: immediate return to reset values.
// CONFIGURATION
//  PIN_ACTIVITY_MONITOR_SYNC_EN defined:
//   pins_i passes a 2-FF synchroniser (reset value 0) before the flag logic.
//   Adds 2 cycles of pin latency, absorbed by SETTLE_CYCLES; total FSM latency unchanged.
//  Not defined: pins_i feeds the flag logic directly; caller guarantees clk_i-synchronous pins.
// STRUCTURE
//  pin_activity_monitor_pkg: FSM state encodings (IDLE, SETTLE, MEASURE, EVAL, DONE);
//   settle counter width function (clog2).
//  Sub-module pin_activity_channel: one pin and its upper neighbour.
//   Holds seen0/seen1/pA/pB, clear and enable inputs, and outputs tgl_ok/adj_ok.
//   Instantiated NUM_CH times by generate.
//  Top holds FSM, settle/window counters, mask capture, result registers, optional sync.
// TESTING
//  1 NUM_CH=8, win_len=16, masks 0xFF, pins = walking-one over 8 ch, then all-zero
//    -> done_o after SETTLE+16+2, ch_ok_o=0xFF, pass_o=1.
//  2 pins[3] stuck 1, others toggling independently, tgl_mask=0xFF
//    -> ch_ok_o=0xF7, pass_o=0.
//  3 pins[4] forced equal to pins[5] (short), both toggling, adj_mask=0xFF
//    -> ch_ok_o=0xCF; repeat with adj_mask[4]=0 -> 0xFF.
//  4 abort_i mid-MEASURE after a passing run
//    -> IDLE, busy_o=0, no done_o, ch_ok_o still 0xFF; start_i while busy ignored.
//  5 win_len_i=0 with WIN_W=4 -> MEASURE lasts 16 cycles.
//    nrst_i low mid-SETTLE -> all outputs 0 next cycle.
//  6 Build with and without PIN_ACTIVITY_MONITOR_SYNC_EN -> identical results and done timing.

Source files
------------

// File: rtl/pin_activity_monitor_pkg.sv
// Shared types and helpers for the pin activity monitor.
package pin_activity_monitor_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_MEASURE,
    ST_EVAL,
    ST_DONE
  } state_t;

  // Bits needed to count 0 .. cycles-1, never narrower than one bit.
  function automatic int settle_cnt_w(input int cycles);
    return (cycles <= 2) ? 1 : $clog2(cycles);
  endfunction

endpackage

// File: rtl/pin_activity_channel.sv
// One monitored pin plus its upper neighbour: sticky level/polarity flags and
// the toggle/short verdicts derived from them.
module pin_activity_channel #(
  parameter logic HAS_UP = 1'b1
) (
  input  logic clk_i,
  input  logic nrst_i,
  input  logic clr_i,
  input  logic en_i,
  input  logic pin_i,
  input  logic pin_up_i,
  input  logic tgl_req_i,
  input  logic adj_req_i,
  output logic tgl_ok_o,
  output logic adj_ok_o
);

  logic seen0_reg, seen1_reg, pa_reg, pb_reg;

  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      seen0_reg <= 1'b0;
      seen1_reg <= 1'b0;
      pa_reg    <= 1'b0;
      pb_reg    <= 1'b0;
    end else if (clr_i) begin
      seen0_reg <= 1'b0;
      seen1_reg <= 1'b0;
      pa_reg    <= 1'b0;
      pb_reg    <= 1'b0;
    end else if (en_i) begin
      seen0_reg <= seen0_reg | ~pin_i;
      seen1_reg <= seen1_reg |  pin_i;
      pa_reg    <= pa_reg    | (~pin_i &  pin_up_i);
      pb_reg    <= pb_reg    | ( pin_i & ~pin_up_i);
    end
  end

  assign tgl_ok_o = ~tgl_req_i | (seen0_reg & seen1_reg);
  // The topmost channel has no neighbour, so its short check always passes.
  assign adj_ok_o = ~(adj_req_i & HAS_UP) | (pa_reg & pb_reg);

endmodule

// File: rtl/pin_activity_monitor.sv
// Restartable pin toggle / neighbour-short checker with per-channel results.
// Optional input synchroniser: define PIN_ACTIVITY_MONITOR_SYNC_EN.
module pin_activity_monitor
  import pin_activity_monitor_pkg::*;
#(
  parameter int NUM_CH        = 8,
  parameter int WIN_W         = 16,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic              clk_i,
  input  logic              nrst_i,
  input  logic              start_i,
  input  logic              abort_i,
  input  logic [WIN_W-1:0]  win_len_i,
  input  logic [NUM_CH-1:0] tgl_mask_i,
  input  logic [NUM_CH-1:0] adj_mask_i,
  input  logic [NUM_CH-1:0] pins_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [NUM_CH-1:0] ch_ok_o,
  output logic              pass_o
);

  localparam int              SET_W       = settle_cnt_w(SETTLE_CYCLES);
  localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SETTLE_CYCLES - 1);

  state_t             state_reg;
  logic [SET_W-1:0]   settle_cnt_reg;
  logic [WIN_W-1:0]   win_cnt_reg;
  logic [WIN_W-1:0]   win_len_reg;
  logic [NUM_CH-1:0]  tgl_mask_reg;
  logic [NUM_CH-1:0]  adj_mask_reg;
  logic               busy_reg;
  logic               done_reg;
  logic [NUM_CH-1:0]  ch_ok_reg;
  logic               pass_reg;

  logic [NUM_CH-1:0]  pins_s;
  logic [NUM_CH-1:0]  pins_up;
  logic [NUM_CH-1:0]  tgl_ok;
  logic [NUM_CH-1:0]  adj_ok;
  logic [NUM_CH-1:0]  adj_lo;
  logic [NUM_CH-1:0]  ch_ok_next;
  logic [WIN_W-1:0]   win_last;
  logic               start_acc;
  logic               run_state;
  logic               measuring;

`ifdef PIN_ACTIVITY_MONITOR_SYNC_EN
  logic [NUM_CH-1:0] sync1_reg, sync2_reg;

  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      sync1_reg <= '0;
      sync2_reg <= '0;
    end else begin
      sync1_reg <= pins_i;
      sync2_reg <= sync1_reg;
    end
  end

  assign pins_s = sync2_reg;
`else
  assign pins_s = pins_i;
`endif

  assign start_acc = start_i & ((state_reg == ST_IDLE) | (state_reg == ST_DONE));
  assign run_state = (state_reg == ST_SETTLE) | (state_reg == ST_MEASURE) | (state_reg == ST_EVAL);
  assign measuring = (state_reg == ST_MEASURE);
  // A zero window length wraps to the full 2^WIN_W cycle window.
  assign win_last  = win_len_reg - WIN_W'(1);
  assign pins_up   = {1'b0, pins_s[NUM_CH-1:1]};

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      pin_activity_channel #(
        .HAS_UP (gi < NUM_CH - 1)
      ) u_ch (
        .clk_i     (clk_i),
        .nrst_i    (nrst_i),
        .clr_i     (start_acc),
        .en_i      (measuring),
        .pin_i     (pins_s[gi]),
        .pin_up_i  (pins_up[gi]),
        .tgl_req_i (tgl_mask_reg[gi]),
        .adj_req_i (adj_mask_reg[gi]),
        .tgl_ok_o  (tgl_ok[gi]),
        .adj_ok_o  (adj_ok[gi])
      );
    end
  endgenerate

  // A short between k and k+1 fails both channels.
  assign adj_lo     = {adj_ok[NUM_CH-2:0], 1'b1};
  assign ch_ok_next = tgl_ok & adj_ok & adj_lo;

  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      state_reg      <= ST_IDLE;
      settle_cnt_reg <= '0;
      win_cnt_reg    <= '0;
      win_len_reg    <= '0;
      tgl_mask_reg   <= '0;
      adj_mask_reg   <= '0;
      busy_reg       <= 1'b0;
      done_reg       <= 1'b0;
      ch_ok_reg      <= '0;
      pass_reg       <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      if (abort_i && run_state) begin
        state_reg <= ST_IDLE;
        busy_reg  <= 1'b0;
      end else begin
        case (state_reg)
          ST_IDLE, ST_DONE: begin
            if (start_i) begin
              state_reg      <= ST_SETTLE;
              busy_reg       <= 1'b1;
              settle_cnt_reg <= '0;
              win_len_reg    <= win_len_i;
              tgl_mask_reg   <= tgl_mask_i;
              adj_mask_reg   <= adj_mask_i;
            end
          end
          ST_SETTLE: begin
            if (settle_cnt_reg == SETTLE_LAST) begin
              state_reg   <= ST_MEASURE;
              win_cnt_reg <= '0;
            end else begin
              settle_cnt_reg <= settle_cnt_reg + SET_W'(1);
            end
          end
          ST_MEASURE: begin
            if (win_cnt_reg == win_last) begin
              state_reg <= ST_EVAL;
            end else begin
              win_cnt_reg <= win_cnt_reg + WIN_W'(1);
            end
          end
          ST_EVAL: begin
            state_reg <= ST_DONE;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b1;
            ch_ok_reg <= ch_ok_next;
            pass_reg  <= &ch_ok_next;
          end
          default: begin
            state_reg <= ST_IDLE;
            busy_reg  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign busy_o  = busy_reg;
  assign done_o  = done_reg;
  assign ch_ok_o = ch_ok_reg;
  assign pass_o  = pass_reg;

endmodule

// File: tb/tb_pin_activity_monitor.sv
// Randomised self-checking bench for pin_activity_monitor against a
// set-of-samples reference model.
module tb_pin_activity_monitor;

  localparam int NUM_CH = 8;
  localparam int SETTLE = 4;

  logic        clk_i = 1'b0;
  logic        nrst_i = 1'b0;
  logic        start_i = 1'b0;
  logic        abort_i = 1'b0;
  logic [15:0] win_len_i = '0;
  logic [3:0]  win_len4_i = 4'd2;
  logic [7:0]  tgl_mask_i = '0;
  logic [7:0]  adj_mask_i = '0;
  logic [7:0]  pins_i = '0;
  logic        busy_o, done_o, pass_o;
  logic [7:0]  ch_ok_o;
  logic        busy4_o, done4_o, pass4_o;
  logic [7:0]  ch_ok4_o;

  int checks = 0;
  int errors = 0;
  logic [7:0] samples_q[$];

  always #5 clk_i = ~clk_i;

  pin_activity_monitor #(.NUM_CH(NUM_CH), .WIN_W(16), .SETTLE_CYCLES(SETTLE)) dut (
    .clk_i(clk_i), .nrst_i(nrst_i), .start_i(start_i), .abort_i(abort_i),
    .win_len_i(win_len_i), .tgl_mask_i(tgl_mask_i), .adj_mask_i(adj_mask_i),
    .pins_i(pins_i), .busy_o(busy_o), .done_o(done_o), .ch_ok_o(ch_ok_o), .pass_o(pass_o)
  );

  pin_activity_monitor #(.NUM_CH(NUM_CH), .WIN_W(4), .SETTLE_CYCLES(SETTLE)) dut4 (
    .clk_i(clk_i), .nrst_i(nrst_i), .start_i(start_i), .abort_i(abort_i),
    .win_len_i(win_len4_i), .tgl_mask_i(tgl_mask_i), .adj_mask_i(adj_mask_i),
    .pins_i(pins_i), .busy_o(busy4_o), .done_o(done4_o), .ch_ok_o(ch_ok4_o), .pass_o(pass4_o)
  );

  // Result from the set of pin vectors seen during the window.
  function automatic logic [7:0] model_ok(input logic [7:0] tm, input logic [7:0] am);
    logic [7:0] res;
    logic [7:0] adj;
    bit lo, hi, pa, pb;
    for (int k = 0; k < NUM_CH; k++) begin
      lo = 0; hi = 0; pa = 0; pb = 0;
      foreach (samples_q[s]) begin
        if (samples_q[s][k] == 1'b0) lo = 1;
        if (samples_q[s][k] == 1'b1) hi = 1;
        if (k < NUM_CH - 1) begin
          if (!samples_q[s][k] &&  samples_q[s][k+1]) pa = 1;
          if ( samples_q[s][k] && !samples_q[s][k+1]) pb = 1;
        end
      end
      res[k] = !tm[k] || (lo && hi);
      adj[k] = (k == NUM_CH - 1) || !am[k] || (pa && pb);
    end
    for (int k = 0; k < NUM_CH; k++)
      if (!adj[k] || (k > 0 && !adj[k-1])) res[k] = 1'b0;
    return res;
  endfunction

  // mode 0: walking one then zeros; 1: pin3 stuck high; 2: pin5 shorted to pin4; 3: random
  function automatic logic [7:0] gen_pins(input int mode, input int j);
    logic [7:0] v;
    if (j >= 0 && j < NUM_CH) v = 8'd1 << j;
    else if (mode == 0)       v = 8'd0;
    else                      v = 8'($urandom);
    if (mode == 1) v[3] = 1'b1;
    if (mode == 2) v[5] = v[4];
    return v;
  endfunction

  task automatic do_reset();
    @(negedge clk_i);
    nrst_i = 1'b0;
    repeat (2) @(negedge clk_i);
    nrst_i = 1'b1;
  endtask

  // Runs one check; lat is the cycle count from the accept cycle to done_o (-1 on timeout).
  task automatic do_run(input int w, input logic [7:0] tm, input logic [7:0] am,
                        input int mode, input int restart_at,
                        output int lat, output logic busy1, output logic [7:0] exp_ok);
    samples_q.delete();
    @(negedge clk_i);
    start_i = 1'b1; win_len_i = 16'(w); tgl_mask_i = tm; adj_mask_i = am;
    @(negedge clk_i);
    start_i = 1'b0;
    busy1 = busy_o;
    lat = -1;
    for (int i = 1; i <= SETTLE + w + 20; i++) begin
      if (done_o === 1'b1) begin
        lat = i;
        break;
      end
      pins_i = gen_pins(mode, i - SETTLE - 1);
      if (i >= SETTLE + 1 && i <= SETTLE + w) samples_q.push_back(pins_i);
      start_i = (i == restart_at);
      @(negedge clk_i);
    end
    start_i = 1'b0;
    if (lat < 0) $display("FAIL run_timeout: no done_o within %0d cycles", SETTLE + w + 20);
    exp_ok = model_ok(tm, am);
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({busy_o, done_o, pass_o, ch_ok_o} !== 11'd0) begin
      errors++;
      $display("FAIL reset_state: got busy=%b done=%b pass=%b ch_ok=%h, want all 0", busy_o, done_o, pass_o, ch_ok_o);
    end
    $display("reset: busy=%b done=%b ch_ok=%h pass=%b", busy_o, done_o, ch_ok_o, pass_o);
  endtask

  task automatic test_walking();
    int lat; logic b; logic [7:0] e;
    do_run(16, 8'hFF, 8'hFF, 0, -1, lat, b, e);
    $display("walking: lat=%0d ch_ok=%h pass=%b", lat, ch_ok_o, pass_o);
    checks++; if (lat != SETTLE + 18) begin errors++; $display("FAIL walk_latency: got %0d want %0d", lat, SETTLE + 18); end
    checks++; if (b !== 1'b1) begin errors++; $display("FAIL walk_busy: got %b want 1", b); end
    checks++; if (ch_ok_o !== 8'hFF || ch_ok_o !== e) begin errors++; $display("FAIL walk_ch_ok: got %h want FF (model %h)", ch_ok_o, e); end
    checks++; if (pass_o !== 1'b1) begin errors++; $display("FAIL walk_pass: got %b want 1", pass_o); end
    @(negedge clk_i);
    checks++; if (done_o !== 1'b0) begin errors++; $display("FAIL done_pulse_width: got %b want 0", done_o); end
  endtask

  task automatic test_stuck();
    int lat; logic b; logic [7:0] e;
    do_run(32, 8'hFF, 8'h00, 1, -1, lat, b, e);
    $display("stuck: lat=%0d ch_ok=%h pass=%b", lat, ch_ok_o, pass_o);
    checks++; if (ch_ok_o !== 8'hF7 || ch_ok_o !== e) begin errors++; $display("FAIL stuck_ch_ok: got %h want F7 (model %h)", ch_ok_o, e); end
    checks++; if (pass_o !== 1'b0) begin errors++; $display("FAIL stuck_pass: got %b want 0", pass_o); end
  endtask

  task automatic test_short();
    int lat; logic b; logic [7:0] e;
    do_run(32, 8'h00, 8'hFF, 2, -1, lat, b, e);
    $display("short: ch_ok=%h pass=%b", ch_ok_o, pass_o);
    checks++; if (ch_ok_o !== 8'hCF || ch_ok_o !== e) begin errors++; $display("FAIL short_ch_ok: got %h want CF (model %h)", ch_ok_o, e); end
    do_run(32, 8'h00, 8'hEF, 2, -1, lat, b, e);
    $display("short_masked: ch_ok=%h pass=%b", ch_ok_o, pass_o);
    checks++; if (ch_ok_o !== 8'hFF || ch_ok_o !== e) begin errors++; $display("FAIL short_masked_ch_ok: got %h want FF (model %h)", ch_ok_o, e); end
    checks++; if (pass_o !== 1'b1) begin errors++; $display("FAIL short_masked_pass: got %b want 1", pass_o); end
  endtask

  task automatic test_masks_zero();
    int lat; logic b; logic [7:0] e;
    do_run(8, 8'h00, 8'h00, 1, -1, lat, b, e);
    $display("masks_zero: ch_ok=%h pass=%b", ch_ok_o, pass_o);
    checks++; if (ch_ok_o !== 8'hFF || pass_o !== 1'b1) begin errors++; $display("FAIL masks_zero: got ch_ok=%h pass=%b want FF/1", ch_ok_o, pass_o); end
  endtask

  task automatic test_abort();
    int lat; int dones; logic b; logic [7:0] e;
    // A start pulse while busy must not restart the run.
    do_run(12, 8'hFF, 8'hFF, 0, 6, lat, b, e);
    $display("start_while_busy: lat=%0d ch_ok=%h", lat, ch_ok_o);
    checks++; if (lat != SETTLE + 14) begin errors++; $display("FAIL busy_start_latency: got %0d want %0d", lat, SETTLE + 14); end
    checks++; if (ch_ok_o !== 8'hFF) begin errors++; $display("FAIL busy_start_ch_ok: got %h want FF", ch_ok_o); end
    @(negedge clk_i);
    start_i = 1'b1; win_len_i = 16'd20; tgl_mask_i = 8'hFF; adj_mask_i = 8'hFF;
    @(negedge clk_i);
    start_i = 1'b0;
    repeat (SETTLE + 4) begin pins_i = 8'h01; @(negedge clk_i); end
    abort_i = 1'b1;
    @(negedge clk_i);
    abort_i = 1'b0;
    $display("abort: busy=%b done=%b ch_ok=%h pass=%b", busy_o, done_o, ch_ok_o, pass_o);
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b want 0", busy_o); end
    dones = 0;
    repeat (40) begin if (done_o === 1'b1) dones++; @(negedge clk_i); end
    checks++; if (dones != 0) begin errors++; $display("FAIL abort_done: got %0d pulses want 0", dones); end
    checks++; if (ch_ok_o !== 8'hFF || pass_o !== 1'b1) begin errors++; $display("FAIL abort_hold: got ch_ok=%h pass=%b want FF/1", ch_ok_o, pass_o); end
  endtask

  task automatic test_back_to_back();
    int lat; int w; logic b; logic [7:0] e, tm, am;
    for (int n = 0; n < 6; n++) begin
      w  = $urandom_range(6, 40);
      tm = 8'($urandom);
      am = 8'($urandom);
      do_run(w, tm, am, (n % 2) ? 3 : 1 + (n % 3), -1, lat, b, e);
      $display("b2b[%0d]: w=%0d tm=%h am=%h lat=%0d ch_ok=%h model=%h pass=%b", n, w, tm, am, lat, ch_ok_o, e, pass_o);
      checks++; if (lat != SETTLE + w + 2) begin errors++; $display("FAIL b2b_latency: got %0d want %0d", lat, SETTLE + w + 2); end
      checks++; if (ch_ok_o !== e) begin errors++; $display("FAIL b2b_ch_ok: got %h want %h", ch_ok_o, e); end
      checks++; if (pass_o !== (&e)) begin errors++; $display("FAIL b2b_pass: got %b want %b", pass_o, &e); end
    end
  endtask

  task automatic test_winwrap();
    int lat4;
    do_reset();
    @(negedge clk_i);
    start_i = 1'b1; win_len_i = 16'd3; win_len4_i = 4'd0; tgl_mask_i = 8'h00; adj_mask_i = 8'h00;
    @(negedge clk_i);
    start_i = 1'b0;
    lat4 = -1;
    for (int i = 1; i <= 60; i++) begin
      if (done4_o === 1'b1) begin lat4 = i; break; end
      pins_i = 8'($urandom);
      @(negedge clk_i);
    end
    win_len4_i = 4'd2;
    $display("winwrap: lat=%0d ch_ok=%h pass=%b", lat4, ch_ok4_o, pass4_o);
    checks++; if (lat4 != SETTLE + 16 + 2) begin errors++; $display("FAIL winwrap_latency: got %0d want %0d", lat4, SETTLE + 18); end
    checks++; if (ch_ok4_o !== 8'hFF || pass4_o !== 1'b1) begin errors++; $display("FAIL winwrap_result: got ch_ok=%h pass=%b want FF/1", ch_ok4_o, pass4_o); end
  endtask

  task automatic test_async_reset();
    int dones;
    @(negedge clk_i);
    start_i = 1'b1; win_len_i = 16'd10; tgl_mask_i = 8'hFF; adj_mask_i = 8'hFF;
    @(negedge clk_i);
    start_i = 1'b0;
    @(negedge clk_i);
    #2 nrst_i = 1'b0;
    #1;
    $display("async_reset: busy=%b done=%b ch_ok=%h pass=%b", busy_o, done_o, ch_ok_o, pass_o);
    checks++;
    if ({busy_o, done_o, pass_o, ch_ok_o} !== 11'd0) begin
      errors++;
      $display("FAIL async_reset: got busy=%b done=%b pass=%b ch_ok=%h want all 0", busy_o, done_o, pass_o, ch_ok_o);
    end
    @(negedge clk_i);
    nrst_i = 1'b1;
    dones = 0;
    repeat (25) begin if (done_o === 1'b1 || busy_o === 1'b1) dones++; @(negedge clk_i); end
    checks++; if (dones != 0) begin errors++; $display("FAIL post_reset_idle: got %0d active cycles want 0", dones); end
  endtask

  initial begin
    test_reset();
    test_walking();
    test_stuck();
    test_short();
    test_masks_zero();
    test_abort();
    test_back_to_back();
    test_winwrap();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
